// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Purpose:
//   Arbitrates four requesters onto one W-bit output channel. The winner's
//   word goes through a per-bit 4:1 mux into a registered output stage, which
//   talks to the consumer with a valid/ready handshake. Producers never drive
//   the mux select; this block owns it.
//
// Configuration:
//   MUX4_ARB_RR_EN  defined   -> round-robin winner selection with a rotating
//                                pointer
//                   undefined -> fixed priority, lowest index wins; no pointer
//
// Ports:
//   clk        in   clock, rising-edge active
//   rst_n      in   asynchronous active-low reset
//   req        in   [3:0]    per-requester request, held until acknowledged
//   in_data    in   [4*W-1:0] requester i data in bits [i*W +: W]
//   in_ack     out  [3:0]    one-hot acceptance pulse (combinational)
//   out_valid  out  output register holds a valid word
//   out_data   out  [W-1:0]  captured word
//   out_src    out  [1:0]    index of the requester that produced out_data
//   out_ready  in   consumer accepts when out_valid && out_ready at an edge
// -----------------------------------------------------------------------------

// Single-bit 4:1 multiplexer; one instance per data bit.
module mux4to1 (
    input  logic [3:0] d,
    input  logic [1:0] sel,
    output logic       y
);

    // Select one of the four data inputs.
    always_comb begin
        y = 1'b0;
        case (sel)
            2'd0:    y = d[0];
            2'd1:    y = d[1];
            2'd2:    y = d[2];
            2'd3:    y = d[3];
            default: y = 1'b0;
        endcase
    end

endmodule

module mux4_rr_arbiter #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] in_data,
    output logic [3:0]     in_ack,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [1:0]     out_src,
    input  logic           out_ready
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [1:0] first_set(input logic [3:0] r);
        logic [1:0] idx;
        casez (r)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    logic [0:0]   state_r;
    logic [W-1:0] out_data_r;
    logic [1:0]   out_src_r;
    logic [1:0]   win_s;
    logic         cap_s;
    logic [W-1:0] mux_out_s;

`ifdef MUX4_ARB_RR_EN
    logic [1:0] ptr_r;

    // Rotate right by amt so bit k of the result is r[(k+amt) mod 4].
    function automatic logic [3:0] rotate_right(input logic [3:0] r,
                                                input logic [1:0] amt);
        logic [7:0] dbl;
        dbl = {r, r} >> amt;
        return dbl[3:0];
    endfunction

    // Round-robin: search from ptr upward; with no request this yields ptr.
    always_comb begin
        win_s = ptr_r + first_set(rotate_right(req, ptr_r));
    end

    // Pointer moves past the winner only when a word is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= 2'd0;
        end else if (cap_s) begin
            ptr_r <= win_s + 2'd1;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    // Fixed priority: requester 0 is highest.
    always_comb begin
        win_s = first_set(req);
    end
`endif

    // Capture when someone requests and the output register is free or
    // draining this cycle; gated by rst_n so no ack escapes during reset.
    always_comb begin
        cap_s = rst_n && (|req) && ((state_r == EMPTY) || out_ready);
    end

    // One-hot acknowledge to the winning requester.
    always_comb begin
        in_ack = 4'b0000;
        if (cap_s) begin
            in_ack = 4'b0001 << win_s;
        end else begin
            in_ack = 4'b0000;
        end
    end

    // Per-bit mux slice sharing the winner select.
    for (genvar b = 0; b < W; b++) begin : g_bit
        mux4to1 u_mux (
            .d   ({in_data[3*W+b], in_data[2*W+b], in_data[W+b], in_data[b]}),
            .sel (win_s),
            .y   (mux_out_s[b])
        );
    end

    // Output stage FSM: capture, drain-without-refill, or hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= EMPTY;
            out_data_r <= '0;
            out_src_r  <= 2'd0;
        end else if (cap_s) begin
            state_r    <= FULL;
            out_data_r <= mux_out_s;
            out_src_r  <= win_s;
        end else if ((state_r == FULL) && out_ready) begin
            // Word consumed and nothing to refill; data/src keep last values.
            state_r    <= EMPTY;
            out_data_r <= out_data_r;
            out_src_r  <= out_src_r;
        end else begin
            state_r    <= state_r;
            out_data_r <= out_data_r;
            out_src_r  <= out_src_r;
        end
    end

    assign out_valid = (state_r == FULL);
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//
// Directed-vector bench for mux4_rr_arbiter (W=8). Expected values are
// hand-computed; where round-robin and fixed priority differ, the expectation
// follows the MUX4_ARB_RR_EN build setting.
// -----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic [3:0]     req;
    logic [4*W-1:0] in_data;
    logic [3:0]     in_ack;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_src;
    logic           out_ready;

    int n_checks;
    int n_errors;

    mux4_rr_arbiter #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in_data   (in_data),
        .in_ack    (in_ack),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        in_data = {d3, d2, d1, d0};
    endtask

    logic [1:0] exp_rot [5];
    logic [1:0] exp_wrap;

    initial begin
        n_checks = 0;
        n_errors = 0;
`ifdef MUX4_ARB_RR_EN
        exp_rot  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_wrap = 2'd3;
`else
        exp_rot  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        exp_wrap = 2'd0;
`endif

        // ---- reset with a pending request ----
        rst_n     = 1'b0;
        req       = 4'b1000;
        out_ready = 1'b1;
        set_data(8'h00, 8'h00, 8'h00, 8'h33);
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_src",   32'(out_src),   32'd0);
        check("rst_ack",   32'(in_ack),    32'd0);

        // ---- release: requester 3 served on first edge ----
        rst_n = 1'b1;
        #1;
        check("rel_ack", 32'(in_ack), 32'b1000);
        step();
        check("rel_valid", 32'(out_valid), 32'd1);
        check("rel_src",   32'(out_src),   32'd3);
        check("rel_data",  32'(out_data),  32'h33);

        // ---- drain without refill ----
        req = 4'b0000;
        #1;
        check("drn_ack", 32'(in_ack), 32'd0);
        step();
        check("drn_valid", 32'(out_valid), 32'd0);
        check("drn_data",  32'(out_data),  32'h33);
        check("drn_src",   32'(out_src),   32'd3);

        // ---- back-to-back, all requesting, consumer always ready ----
        req = 4'b1111;
        set_data(8'h10, 8'h11, 8'h12, 8'h13);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("b2b_ack", 32'(in_ack), 32'(4'b0001 << exp_rot[i]));
            step();
            check("b2b_valid", 32'(out_valid), 32'd1);
            check("b2b_src",   32'(out_src),   32'(exp_rot[i]));
            check("b2b_data",  32'(out_data),  32'(8'h10 + 8'(exp_rot[i])));
        end

        // ---- load 8'h11 from requester 1, then stall ----
        req = 4'b0010;
        set_data(8'h00, 8'h11, 8'h00, 8'h00);
        step();
        check("stl_load_src",  32'(out_src),  32'd1);
        check("stl_load_data", 32'(out_data), 32'h11);
        out_ready = 1'b0;
        set_data(8'h00, 8'h22, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stl_ack", 32'(in_ack), 32'd0);
            step();
            check("stl_data",  32'(out_data),  32'h11);
            check("stl_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("stl_rel_ack", 32'(in_ack), 32'b0010);
        step();
        check("stl_rel_src",  32'(out_src),  32'd1);
        check("stl_rel_data", 32'(out_data), 32'h22);

        // ---- pointer wrap: win 3, then req 1001 twice ----
        req = 4'b1000;
        set_data(8'h55, 8'h00, 8'h00, 8'h44);
        step();
        check("wrp_src3", 32'(out_src), 32'd3);
        req = 4'b1001;
        set_data(8'h55, 8'h00, 8'h00, 8'h66);
        #1;
        check("wrp_ack0", 32'(in_ack), 32'b0001);
        step();
        check("wrp_src0",  32'(out_src),  32'd0);
        check("wrp_data0", 32'(out_data), 32'h55);
        step();
        check("wrp_src_next", 32'(out_src), 32'(exp_wrap));

        // ---- reset mid-FULL holding 8'hA5 ----
        req = 4'b0001;
        set_data(8'hA5, 8'h00, 8'h00, 8'h00);
        step();
        check("mid_load", 32'(out_data), 32'hA5);
        out_ready = 1'b0;
        req = 4'b0100;
        set_data(8'h00, 8'h00, 8'h77, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_data",  32'(out_data),  32'd0);
        check("mid_src",   32'(out_src),   32'd0);
        check("mid_ack",   32'(in_ack),    32'd0);
        rst_n = 1'b1;
        #1;
        check("mid_rel_ack", 32'(in_ack), 32'b0100);
        step();
        check("mid_rel_valid", 32'(out_valid), 32'd1);
        check("mid_rel_src",   32'(out_src),   32'd2);
        check("mid_rel_data",  32'(out_data),  32'h77);

        req = 4'b0000;
        out_ready = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Arbitrates four requesters for one shared W-bit output channel. Each capture routes the winner's data through `mux4to1` select logic into a registered output stage. The output stage uses a valid/ready handshake toward the consumer. The block sits between four producers and the single datapath consumer, and it owns the mux select so that producers never drive `sel` directly.

## Interface
- `W`, default 8, data width per requester.

- `clk` input, 1 bit, single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit, reset; asynchronous assert, active-low.
- `req` input, 4 bits, per-requester request; held high with stable data until acknowledged.
- `in_data` input, 4*W bits, requester i's data in bits [i*W +: W].
- `in_ack` output, 4 bits, one-hot acceptance pulse, combinational.
- `out_valid` output, 1 bit, output register holds a valid word.
- `out_data` output, W bits, captured word.
- `out_src` output, 2 bits, index of the requester that produced `out_data`.
- `out_ready` input, 1 bit, consumer accepts the word when `out_valid && out_ready` at a rising edge.

## Operation
- **Datapath:**
  - W instances of `mux4to1`, one per bit.
  - Bit instance b takes {in_data[3*W+b], in_data[2*W+b], in_data[W+b], in_data[b]}.
  - Shared select is the internal 2-bit `win`.
- **State machine:** two states, EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
- **`cap` (capture enable):**
  - cap = |req && (EMPTY || out_ready).
  - In FULL, a new word is captured in the same cycle the old one drains, so throughput is one word per cycle.
- **On cap at a rising edge:**
  - `out_data` ← mux output.
  - `out_src` ← `win`.
  - `out_valid` ← 1.
- **Acknowledge:** in_ack[i] = cap && (win == i), so at most one bit is high.
- **Requester obligation:** the requester treats in_ack[i] high at a rising edge as consumption and drops or renews `req` and data on the following cycle.
- **Drain without refill:** FULL && out_ready && !(|req) → `out_valid` ← 0, go to EMPTY. `out_data` and `out_src` keep their last values.
- **Stall:**
  - FULL && !out_ready → hold `out_data`, `out_src` and `out_valid`.
  - `in_ack` stays 0.
  - `req` is ignored.
- **Winner selection, round-robin:**
  - Internal 2-bit pointer `ptr`.
  - Search starts at `ptr` and proceeds ptr, ptr+1, ptr+2, ptr+3, modulo 4, wrapping 3→0.
  - The first asserted `req` wins.
  - On cap, `ptr` ← win+1 mod 4.
  - `ptr` changes only on cap.
- **No request:** `win` = `ptr` when no request is pending. The value is don't-care because cap=0.

## Timing
- **Reset values** (while `rst_n`=0, asynchronous):
  - `out_valid`=0, `out_data`=0, `out_src`=0, `ptr`=0; state EMPTY.
  - `in_ack`=0 during reset, since cap is gated by rst_n.
- **Latency:** `req` high in cycle N with EMPTY → `out_valid`=1 from cycle N+1, carrying requester data sampled at edge N.
- **Combinational paths:**
  - `in_ack` depends combinationally on `req`, `out_ready` and state.
  - No other path is combinational.
- **Simultaneous events:**
  - Consumer accept and a new capture in the same cycle: the old word is consumed and the new word is loaded; `out_valid` stays 1.
  - All four requesting: grants rotate 0,1,2,3,0… when the output is consumed every cycle.
- **Reset mid-operation:** the pending output word is discarded and `ptr` returns to 0. A requester unacknowledged at reset keeps `req` and is served normally after release.
- **Reset release:** first capture possible at the first rising edge with `rst_n`=1.

## Configuration
- Macro `MUX4_ARB_RR_EN`.
  - **Defined:** round-robin selection as above.
  - **Undefined:**
    - Fixed priority; lowest index wins, so req[0] is highest.
    - `ptr` is not implemented.
    - All other behaviour is identical.

## Test plan
- **Reset:** assert `rst_n`=0 mid-FULL with `out_data`=8'hA5 → `out_valid`=0, `out_data`=0, `out_src`=0, `in_ack`=0 immediately. After release, req=4'b1000 → `out_src`=3 one cycle later.
- **Single request:** EMPTY, req=4'b0100, data2=8'h3C → in_ack=4'b0100 in that cycle. Next cycle `out_valid`=1, `out_data`=8'h3C, `out_src`=2.
- **Back-to-back rotation:** req=4'b1111, `out_ready`=1 constantly, data_i=8'h10+i, RR_EN defined → `out_src` sequence 0,1,2,3,0, one word per cycle, no gaps.
- **Stall:** FULL with `out_data`=8'h11, `out_ready`=0 for 5 cycles, req=4'b0010 → `in_ack`=0 and `out_data` stays 8'h11. The cycle `out_ready`=1 gives in_ack=4'b0010, and the next word comes from requester 1.
- **Pointer wrap:** last win=3, then req=4'b1001 → requester 0 wins and `ptr` becomes 1.
- **Fixed priority:** RR_EN undefined, req=4'b1111 with `out_ready`=1 → `out_src`=0 every cycle; requester 3 is never acknowledged while req[0]=1.
